// File: rtl/bram_bank_loader.sv
// ============================================================================
//  Module   : bram_bank_loader
//  Purpose  : Streams 128-bit words into 16 interleaved BRAM bank write ports.
//  Option   : BRAM_LOADER_CHECKSUM_EN adds a running 32-bit lane checksum.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module bram_bank_loader #(
    parameter int DW    = 128,
    parameter int AW    = 9,
    parameter int NB    = 16,
    parameter int DEPTH = 512
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          iStart,
    input  logic [13:0]   iWordCnt,
    input  logic          i_valid,
    input  logic [DW-1:0] i_data,
    output logic          o_ready,
    output logic [NB-1:0] o_ena,
    output logic [NB-1:0] o_wea,
    output logic [AW-1:0] o_addra,
    output logic [DW-1:0] o_dia,
    output logic          oBusy,
    output logic          oDone,
    output logic [31:0]   o_checksum
);

    localparam int            BW        = $clog2(NB);
    localparam int            CW        = 14;
    localparam logic [CW-1:0] MAX_WORDS = CW'(NB * DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   k_q, k_d;
    logic [NB-1:0]   ena_q, ena_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   dia_q, dia_d;
    logic            done_q, done_d;
    logic            accept;
    logic [CW-1:0]   start_cnt;

    // Clamping keeps the address field inside the bank depth.
    assign start_cnt = (iWordCnt > MAX_WORDS) ? MAX_WORDS : iWordCnt;
    assign accept    = (state_q == S_LOAD) && i_valid;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        k_d     = k_q;
        ena_d   = '0;
        addr_d  = addr_q;
        dia_d   = dia_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (iStart) begin
                    cnt_d   = start_cnt;
                    k_d     = '0;
                    state_d = (start_cnt == '0) ? S_FLUSH : S_LOAD;
                end
            end
            S_LOAD: begin
                if (accept) begin
                    ena_d  = NB'(1) << k_q[BW-1:0];
                    addr_d = k_q[BW +: AW];
                    dia_d  = i_data;
                    k_d    = k_q + CW'(1);
                    if (k_q == cnt_q - CW'(1)) begin
                        state_d = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            k_q     <= '0;
            ena_q   <= '0;
            addr_q  <= '0;
            dia_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            k_q     <= k_d;
            ena_q   <= ena_d;
            addr_q  <= addr_d;
            dia_q   <= dia_d;
            done_q  <= done_d;
        end
    end

    assign o_ready = (state_q == S_LOAD);
    assign oBusy   = (state_q != S_IDLE);
    assign oDone   = done_q;
    assign o_ena   = ena_q;
    assign o_wea   = ena_q;
    assign o_addra = addr_q;
    assign o_dia   = dia_q;

`ifdef BRAM_LOADER_CHECKSUM_EN
    logic [31:0] chk_q, chk_d, lane_sum;

    always_comb begin
        lane_sum = '0;
        for (int i = 0; i < DW / 32; i++) begin
            lane_sum = lane_sum + i_data[i*32 +: 32];
        end
        chk_d = chk_q;
        if ((state_q == S_IDLE) && iStart) begin
            chk_d = '0;
        end else if (accept) begin
            chk_d = chk_q + lane_sum;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            chk_q <= '0;
        end else begin
            chk_q <= chk_d;
        end
    end

    assign o_checksum = chk_q;
`else
    assign o_checksum = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bram_bank_loader.sv
// ============================================================================
//  Module   : tb_bram_bank_loader
//  Purpose  : Randomised scoreboard bench for bram_bank_loader.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bram_bank_loader;

    logic          clk = 1'b0;
    logic          rst;
    logic          iStart;
    logic [13:0]   iWordCnt;
    logic          i_valid;
    logic [127:0]  i_data;
    logic          o_ready;
    logic [15:0]   o_ena;
    logic [15:0]   o_wea;
    logic [8:0]    o_addra;
    logic [127:0]  o_dia;
    logic          oBusy;
    logic          oDone;
    logic [31:0]   o_checksum;

    bram_bank_loader dut (
        .clk        (clk),
        .rst        (rst),
        .iStart     (iStart),
        .iWordCnt   (iWordCnt),
        .i_valid    (i_valid),
        .i_data     (i_data),
        .o_ready    (o_ready),
        .o_ena      (o_ena),
        .o_wea      (o_wea),
        .o_addra    (o_addra),
        .o_dia      (o_dia),
        .oBusy      (oBusy),
        .oDone      (oDone),
        .o_checksum (o_checksum)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           bank;
        int           addr;
        logic [127:0] data;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] done_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    bit          mon_on = 1'b0;
    bit          acc_prev = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every strobe must match the oldest expected write, every done the oldest expected checksum.
    initial begin
        wr_t         e;
        logic [31:0] c;
        logic [15:0] oh;
        forever begin
            @(negedge clk);
            if (mon_on) begin
                chk("strobe_timing", 128'(o_ena != 16'd0), 128'(acc_prev));
                if (o_ena != 16'd0) begin
                    chk("wea_eq_ena", 128'(o_wea), 128'(o_ena));
                    if (exp_q.size() == 0) begin
                        chk("unexpected_strobe", 128'(o_ena), 128'd0);
                    end else begin
                        e  = exp_q.pop_front();
                        oh = 16'd1 << e.bank;
                        chk("bank_onehot", 128'(o_ena), 128'(oh));
                        chk("addr", 128'(o_addra), 128'(e.addr));
                        chk("data", o_dia, e.data);
                    end
                end
                if (oDone) begin
                    if (done_q.size() == 0) begin
                        chk("unexpected_done", 128'(oDone), 128'd0);
                    end else begin
                        c = done_q.pop_front();
                        chk("checksum", 128'(o_checksum), 128'(c));
                        chk("writes_before_done", 128'(exp_q.size()), 128'd0);
                    end
                end
            end
            acc_prev = i_valid && o_ready && !rst;
        end
    end

    // vmode: 0 always valid, 1 toggling, 2 random 60%; dmode: 0 index in all lanes, 1 random.
    task automatic do_load(input int n, input int vmode, input int dmode,
                           input int ign_at, input int rst_at, input bit b2b);
        int           m;
        int           idx;
        int           guard;
        int           c;
        bit           tog;
        bit           seen;
        bit           v;
        logic [127:0] w;
        logic [127:0] words[$];
        logic [31:0]  sum;
        wr_t          e;

        m   = (n > 8192) ? 8192 : n;
        sum = 32'd0;
        for (int j = 0; j < m; j++) begin
            if (dmode == 0) w = {4{32'(j)}};
            else            w = {$urandom, $urandom, $urandom, $urandom};
            words.push_back(w);
            sum = sum + w[31:0] + w[63:32] + w[95:64] + w[127:96];
            e.bank = j % 16;
            e.addr = j / 16;
            e.data = w;
            exp_q.push_back(e);
        end
`ifndef BRAM_LOADER_CHECKSUM_EN
        sum = 32'd0;
`endif
        if (rst_at < 0 || rst_at >= m) done_q.push_back(sum);

        if (!b2b) begin
            @(posedge clk);
            #1;
        end
        iStart   = 1'b1;
        iWordCnt = 14'(n);

        if (m == 0) begin
            @(posedge clk);
            #1;
            iStart = 1'b0;
        end

        idx   = 0;
        guard = 0;
        tog   = 1'b1;
        while (idx < m) begin
            if (guard > 4 * m + 20) begin
                chk("accept_timeout", 128'(idx), 128'(m));
                break;
            end
            guard++;
            @(posedge clk);
            #1;
            iStart = 1'b0;
            if (idx == rst_at) begin
                rst     = 1'b1;
                i_valid = 1'b1;
                @(posedge clk);
                #1;
                rst     = 1'b0;
                i_valid = 1'b0;
                @(negedge clk);
                chk("pending_after_reset", 128'(exp_q.size()), 128'(m - rst_at));
                chk("busy_after_reset", 128'(oBusy), 128'd0);
                exp_q.delete();
                repeat (4) @(negedge clk);
                return;
            end
            if (idx == ign_at) begin
                iStart   = 1'b1;
                iWordCnt = 14'd5;
            end
            case (vmode)
                0:       v = 1'b1;
                1:       begin v = tog; tog = ~tog; end
                default: v = ($urandom_range(99) < 60);
            endcase
            i_valid = v;
            i_data  = v ? words[idx] : {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            if (guard == 1) chk("ready_after_start", 128'(o_ready), 128'd1);
            if (i_valid && o_ready) idx++;
        end

        c    = 0;
        seen = 1'b0;
        while (!seen && c < 10) begin
            @(negedge clk);
            c++;
            if (oDone) seen = 1'b1;
        end
        chk("done_seen", 128'(seen), 128'd1);
        if (seen) chk("done_latency", 128'(c), 128'd2);
        i_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        iStart   = 1'b0;
        iWordCnt = 14'd0;
        i_valid  = 1'b1;
        i_data   = {$urandom, $urandom, $urandom, $urandom};
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready",    128'(o_ready),    128'd0);
        chk("rst_ena",      128'(o_ena),      128'd0);
        chk("rst_wea",      128'(o_wea),      128'd0);
        chk("rst_addra",    128'(o_addra),    128'd0);
        chk("rst_dia",      o_dia,            128'd0);
        chk("rst_busy",     128'(oBusy),      128'd0);
        chk("rst_done",     128'(oDone),      128'd0);
        chk("rst_checksum", 128'(o_checksum), 128'd0);
        @(posedge clk);
        #1;
        rst     = 1'b0;
        i_valid = 1'b0;
        mon_on  = 1'b1;

        do_load(20,    0, 0, -1, -1, 1'b0);
        do_load(32,    1, 1, -1, -1, 1'b0);
        do_load(0,     0, 1, -1, -1, 1'b0);
        do_load(16383, 0, 1, -1, -1, 1'b0);
        do_load(40,    2, 1, 15, -1, 1'b0);
        do_load(40,    0, 1, -1, 10, 1'b0);
        do_load(20,    2, 1, -1, -1, 1'b0);
        for (int t = 0; t < 6; t++) begin
            do_load(int'($urandom_range(50)), 2, 1, -1, -1, (t % 2) == 1);
        end

        repeat (4) @(negedge clk);
        chk("leftover_writes", 128'(exp_q.size()), 128'd0);
        chk("leftover_dones",  128'(done_q.size()), 128'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
